// File: rtl/reveal_flood_ctrl.sv
// Reveal controller for the 16x16 minesweeper board RAM.
// Reveals the clicked cell and, for zero-count cells, flood-fills through
// connected zero cells with a LIFO of pending addresses.
module reveal_flood_ctrl #(
    parameter int unsigned STACK_DEPTH = 256,
    parameter int unsigned RD_LAT      = 2     // must be >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_addr,
    output logic [7:0] ram_read_addr,
    input  logic [0:6] ram_dout,
    output logic [7:0] ram_write_addr,
    output logic [0:6] ram_din,
    output logic       ram_we,
    output logic       busy,
    output logic       done,
    output logic       hit_bomb,
    output logic [8:0] cells_revealed
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CELLS  = 256;
    localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W  = $clog2(STACK_DEPTH);
    localparam int unsigned WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EVAL,
        S_WRITE,
        S_NEIGH,
        S_POP,
        S_FIN
    } state_t;

    state_t              state;
    state_t              state_d;

    logic [ADDR_W-1:0]   cur;
    logic [0:6]          cell_q;
    logic [2:0]          k;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     sp_m1;
    logic [IDX_W-1:0]    top_idx;
    logic [CELLS-1:0]    queued;
    logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

    logic [3:0]          row;
    logic [3:0]          col;
    logic                nb_up;
    logic                nb_down;
    logic                nb_left;
    logic                nb_right;
    logic                nb_ok_c;
    logic [3:0]          nb_row;
    logic [3:0]          nb_col;
    logic [ADDR_W-1:0]   nb_addr_c;
    logic                push_c;
    logic                stack_empty_c;
    logic                accept_c;
    logic                eval_skip_c;
    logic                eval_bomb_c;

    assign row           = cur[7:4];
    assign col           = cur[3:0];
    assign sp_m1         = sp - SP_W'(1);
    assign top_idx       = sp_m1[IDX_W-1:0];
    assign stack_empty_c = (sp == SP_W'(0));

    // Neighbor k: direction decode, board-edge rejection and address.
    always_comb begin
        nb_up    = (k == 3'd0) || (k == 3'd1) || (k == 3'd2);
        nb_down  = (k == 3'd5) || (k == 3'd6) || (k == 3'd7);
        nb_left  = (k == 3'd0) || (k == 3'd3) || (k == 3'd5);
        nb_right = (k == 3'd2) || (k == 3'd4) || (k == 3'd7);
        nb_ok_c  = !(nb_up    && (row == 4'd0))  &&
                   !(nb_down  && (row == 4'd15)) &&
                   !(nb_left  && (col == 4'd0))  &&
                   !(nb_right && (col == 4'd15));
        nb_row   = row;
        nb_col   = col;
        if (nb_up)    nb_row = row - 4'd1;
        if (nb_down)  nb_row = row + 4'd1;
        if (nb_left)  nb_col = col - 4'd1;
        if (nb_right) nb_col = col + 4'd1;
        nb_addr_c = {nb_row, nb_col};
    end

    assign push_c      = (state == S_NEIGH) && nb_ok_c && !queued[nb_addr_c];
    assign eval_skip_c = ram_dout[1] || ram_dout[2];
    assign eval_bomb_c = (state == S_EVAL) && !eval_skip_c && ram_dout[0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    accept_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == WAIT_W'(RD_LAT - 2)) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (eval_skip_c)      state_d = S_POP;
                else if (ram_dout[0]) state_d = S_FIN;
                else                  state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cell_q[3:6] == 4'd0) state_d = S_NEIGH;
                else                     state_d = S_POP;
            end
            S_NEIGH: begin
                if (k == 3'd7) state_d = S_POP;
            end
            S_POP: begin
                if (stack_empty_c) state_d = S_FIN;
                else               state_d = S_FETCH;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur            <= '0;
            cell_q         <= '0;
            k              <= '0;
            wait_cnt       <= '0;
            sp             <= '0;
            queued         <= '0;
            ram_read_addr  <= '0;
            ram_write_addr <= '0;
            ram_din        <= '0;
            ram_we         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            hit_bomb       <= 1'b0;
            cells_revealed <= '0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        cur                <= start_addr;
                        queued             <= '0;
                        queued[start_addr] <= 1'b1;
                        sp                 <= '0;
                        hit_bomb           <= 1'b0;
                        cells_revealed     <= '0;
                        busy               <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ram_read_addr <= cur;
                    wait_cnt      <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                S_EVAL: begin
                    cell_q <= ram_dout;
                    if (eval_bomb_c) begin
                        ram_write_addr <= cur;
                        ram_din        <= {ram_dout[0], 1'b1, ram_dout[2:6]};
                        ram_we         <= 1'b1;
                        hit_bomb       <= 1'b1;
                        cells_revealed <= cells_revealed + CNT_W'(1);
                        sp             <= '0;
                    end
                end
                S_WRITE: begin
                    ram_write_addr <= cur;
                    ram_din        <= {cell_q[0], 1'b1, cell_q[2:6]};
                    ram_we         <= 1'b1;
                    cells_revealed <= cells_revealed + CNT_W'(1);
                    k              <= '0;
                end
                S_NEIGH: begin
                    k <= k + 3'd1;
                    if (push_c) begin
                        queued[nb_addr_c] <= 1'b1;
                        sp                <= sp + SP_W'(1);
                    end
                end
                S_POP: begin
                    if (!stack_empty_c) begin
                        cur <= stack_mem[top_idx];
                        sp  <= sp_m1;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Stack storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_c) stack_mem[sp[IDX_W-1:0]] <= nb_addr_c;
    end

    // Each cell is queued at most once, so a full-stack push is a logic bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push_c |-> (sp < SP_W'(STACK_DEPTH)));

endmodule

// File: tb/tb_reveal_flood_ctrl.sv
// Directed bench for reveal_flood_ctrl with a behavioural board RAM.
module tb_reveal_flood_ctrl;

    localparam int LIMIT = 5000;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] ram_read_addr;
    logic [0:6] ram_dout;
    logic [7:0] ram_write_addr;
    logic [0:6] ram_din;
    logic       ram_we;
    logic       busy;
    logic       done;
    logic       hit_bomb;
    logic [8:0] cells_revealed;

    logic       load_req;
    int         load_pat;
    logic [0:6] mem    [256];
    int         wr_cnt [256];

    int checks;
    int errors;

    typedef struct {
        int         pat;
        logic [7:0] addr;
        int         exp_writes;
        int         exp_cells;
        int         exp_hit;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [7];

    reveal_flood_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_dout       (ram_dout),
        .ram_write_addr (ram_write_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .busy           (busy),
        .done           (done),
        .hit_bomb       (hit_bomb),
        .cells_revealed (cells_revealed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board patterns: 0 all count 3; 1 bomb at 00; 2 empty; 3 barrier col 7;
    // 4 all count 3 with 35 revealed; 5 empty with 11 flagged; 6 count 1 except 77.
    function automatic logic [0:6] pat_word(input int pat, input logic [7:0] a);
        logic b, r, f;
        logic [3:0] c;
        b = 1'b0; r = 1'b0; f = 1'b0; c = 4'd0;
        case (pat)
            0: c = 4'd3;
            1: if (a == 8'h00) b = 1'b1;
            3: if (a[3:0] == 4'd7) c = 4'd1;
            4: begin c = 4'd3; if (a == 8'h35) r = 1'b1; end
            5: if (a == 8'h11) f = 1'b1;
            6: c = (a == 8'h77) ? 4'd0 : 4'd1;
            default: ;
        endcase
        return {b, r, f, c};
    endfunction

    // Addresses that must never be written for a pattern/start pair.
    function automatic bit forbidden(input int pat, input logic [7:0] a);
        case (pat)
            0: return a != 8'h35;
            1: return a != 8'h00;
            3: return a[3:0] >= 4'd8;
            4: return 1'b1;
            5: return a == 8'h11;
            6: return !((a[7:4] >= 4'd6) && (a[7:4] <= 4'd8) &&
                        (a[3:0] >= 4'd6) && (a[3:0] <= 4'd8));
            default: return 1'b0;
        endcase
    endfunction

    // Board RAM: registered read data, write port, per-address write log.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]    <= pat_word(load_pat, 8'(i));
                wr_cnt[i] <= 0;
            end
        end else if (ram_we) begin
            mem[ram_write_addr]    <= ram_din;
            wr_cnt[ram_write_addr] <= wr_cnt[ram_write_addr] + 1;
        end
        ram_dout <= mem[ram_read_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int total_writes();
        int s;
        s = 0;
        for (int i = 0; i < 256; i++) s += wr_cnt[i];
        return s;
    endfunction

    task automatic do_load(input int pat);
        load_pat = pat;
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int mid_at, input string tag);
        int cyc, dup, forb, derr;
        logic [0:6] w;
        do_load(v.pat);
        start_addr = v.addr;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == mid_at) begin
                start      = 1'b1;
                start_addr = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_done_cycle"}, cyc, v.exp_cycles);
        chk({tag, "_cells"}, int'(cells_revealed), v.exp_cells);
        chk({tag, "_hit"}, int'(hit_bomb), v.exp_hit);
        // a start coinciding with done must be ignored
        start      = 1'b1;
        start_addr = v.addr;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_start_on_done_busy"}, int'(busy), 0);
        dup = 0; forb = 0; derr = 0;
        for (int i = 0; i < 256; i++) begin
            if (wr_cnt[i] > 1) dup++;
            if (wr_cnt[i] > 0) begin
                if (forbidden(v.pat, 8'(i))) forb++;
                w    = pat_word(v.pat, 8'(i));
                w[1] = 1'b1;
                if (mem[i] !== w) derr++;
            end
        end
        chk({tag, "_writes"}, total_writes(), v.exp_writes);
        chk({tag, "_dup_writes"}, dup, 0);
        chk({tag, "_forbidden_writes"}, forb, 0);
        chk({tag, "_write_data"}, derr, 0);
    endtask

    initial begin
        int nw, cyc, snap;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = 8'h00;
        load_req   = 1'b0;
        load_pat   = 2;

        vecs[0] = '{pat: 0, addr: 8'h35, exp_writes: 1,   exp_cells: 1,   exp_hit: 0, exp_cycles: 6};
        vecs[1] = '{pat: 1, addr: 8'h00, exp_writes: 1,   exp_cells: 1,   exp_hit: 1, exp_cycles: 4};
        vecs[2] = '{pat: 2, addr: 8'h00, exp_writes: 256, exp_cells: 256, exp_hit: 0, exp_cycles: 3329};
        vecs[3] = '{pat: 3, addr: 8'h10, exp_writes: 128, exp_cells: 128, exp_hit: 0, exp_cycles: 1537};
        vecs[4] = '{pat: 4, addr: 8'h35, exp_writes: 0,   exp_cells: 0,   exp_hit: 0, exp_cycles: 5};
        vecs[5] = '{pat: 5, addr: 8'h00, exp_writes: 255, exp_cells: 255, exp_hit: 0, exp_cycles: 3320};
        vecs[6] = '{pat: 6, addr: 8'h77, exp_writes: 9,   exp_cells: 9,   exp_hit: 0, exp_cycles: 54};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_hit", int'(hit_bomb), 0);
        chk("rst_cells", int'(cells_revealed), 0);
        chk("rst_raddr", int'(ram_read_addr), 0);
        chk("rst_waddr", int'(ram_write_addr), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], -1, $sformatf("vec%0d", i));

        // second click mid-reveal must not disturb the running reveal
        run_vec(vecs[6], 20, "mid_start");

        // reset in the middle of a flood fill
        do_load(2);
        start_addr = 8'h00;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nw = 0; cyc = 0;
        while (nw < 10 && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ram_we) nw++;
        end
        chk("midrst_reach_10_writes", nw, 10);
        #2 reset = 1'b1;
        #1;
        chk("midrst_we", int'(ram_we), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        snap = total_writes();
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_more_writes", total_writes(), snap);
        chk("midrst_idle_busy", int'(busy), 0);
        run_vec(vecs[0], -1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
